// File: rtl/hs32_mem_arb_if.sv
// Bus bundle between hs32_mem_arb, its two requesters (exec = port 0, fetch = port 1)
// and the external memory. The arbiter uses the slave view; the environment uses master.
interface hs32_mem_arb_if;
  // Handshake: a requester raises reqN with stable addrN/dtwN/rwN and holds them until it
  // sees a one-cycle ackN (err qualifies it), then drops reqN. On the memory side, mreq
  // is held with stable maddr/mdtw/mrw until a one-cycle mack, which carries mdtr on reads.
  logic        req0;
  logic [31:0] addr0;
  logic [31:0] dtw0;
  logic        rw0;
  logic        ack0;
  logic [31:0] dtr0;
  logic        req1;
  logic [31:0] addr1;
  logic [31:0] dtw1;
  logic        rw1;
  logic        ack1;
  logic [31:0] dtr1;
  logic        err;
  logic [31:0] maddr;
  logic [31:0] mdtw;
  logic        mrw;
  logic        mreq;
  logic        mack;
  logic [31:0] mdtr;
  logic        gnt;
  logic        busy;

  modport slave (
    input  req0, addr0, dtw0, rw0, req1, addr1, dtw1, rw1, mack, mdtr,
    output ack0, dtr0, ack1, dtr1, err, maddr, mdtw, mrw, mreq, gnt, busy
  );

  modport master (
    output req0, addr0, dtw0, rw0, req1, addr1, dtw1, rw1, mack, mdtr,
    input  ack0, dtr0, ack1, dtr1, err, maddr, mdtw, mrw, mreq, gnt, busy
  );
endinterface

// File: rtl/hs32_mem_arb.sv
// Two-port memory arbiter: latches one winning request, runs a single memory
// transaction with optional timeout, and returns a one-cycle ack to the winner.
module hs32_mem_arb #(
  parameter bit          FAIR    = 1'b1,
  parameter int unsigned TIMEOUT = 0,
  parameter int unsigned TW      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  hs32_mem_arb_if.slave        bus,
  output logic [1:0]           dbg_state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, MEM = 2'd1, ACK = 2'd2} state_e;

  localparam int unsigned     TO_LAST_I = (TIMEOUT == 32'd0) ? 32'd0 : TIMEOUT - 32'd1;
  localparam logic [TW-1:0]   TO_LAST   = TO_LAST_I[TW-1:0];

  state_e        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          pri_q, pri_d;
  logic          gnt_q, gnt_d;
  logic          mreq_q, mreq_d;
  logic          busy_q, busy_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          err_q, err_d;
  logic [31:0]   dtr0_q, dtr0_d;
  logic [31:0]   dtr1_q, dtr1_d;
  logic [31:0]   maddr_q, maddr_d;
  logic [31:0]   mdtw_q, mdtw_d;
  logic          mrw_q, mrw_d;
  logic          sel;
  logic          timeout_hit;

  assign timeout_hit = (TIMEOUT != 32'd0) && (cnt_q == TO_LAST);

  // pri_q names the port favoured on the next tie; it starts at port 0 and
  // flips to the other port after each completed transaction.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pri_d   = pri_q;
    gnt_d   = gnt_q;
    mreq_d  = mreq_q;
    busy_d  = busy_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    err_d   = 1'b0;
    dtr0_d  = dtr0_q;
    dtr1_d  = dtr1_q;
    maddr_d = maddr_q;
    mdtw_d  = mdtw_q;
    mrw_d   = mrw_q;
    sel     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          if (bus.req0 && bus.req1) sel = FAIR ? pri_q : 1'b0;
          else                      sel = bus.req1;
          gnt_d   = sel;
          maddr_d = sel ? bus.addr1 : bus.addr0;
          mdtw_d  = sel ? bus.dtw1  : bus.dtw0;
          mrw_d   = sel ? bus.rw1   : bus.rw0;
          mreq_d  = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = MEM;
        end
      end
      MEM: begin
        if (bus.mack) begin
          mreq_d  = 1'b0;
          state_d = ACK;
          if (!mrw_q) begin
            if (gnt_q) dtr1_d = bus.mdtr;
            else       dtr0_d = bus.mdtr;
          end
          if (gnt_q) ack1_d = 1'b1;
          else       ack0_d = 1'b1;
        end else if (timeout_hit) begin
          mreq_d  = 1'b0;
          err_d   = 1'b1;
          state_d = ACK;
          if (gnt_q) begin
            dtr1_d = '0;
            ack1_d = 1'b1;
          end else begin
            dtr0_d = '0;
            ack0_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      ACK: begin
        pri_d   = ~gnt_q;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pri_q   <= 1'b0;
      gnt_q   <= 1'b0;
      mreq_q  <= 1'b0;
      busy_q  <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err_q   <= 1'b0;
      dtr0_q  <= '0;
      dtr1_q  <= '0;
      maddr_q <= '0;
      mdtw_q  <= '0;
      mrw_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pri_q   <= pri_d;
      gnt_q   <= gnt_d;
      mreq_q  <= mreq_d;
      busy_q  <= busy_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      err_q   <= err_d;
      dtr0_q  <= dtr0_d;
      dtr1_q  <= dtr1_d;
      maddr_q <= maddr_d;
      mdtw_q  <= mdtw_d;
      mrw_q   <= mrw_d;
    end
  end

  assign bus.ack0     = ack0_q;
  assign bus.ack1     = ack1_q;
  assign bus.dtr0     = dtr0_q;
  assign bus.dtr1     = dtr1_q;
  assign bus.err      = err_q;
  assign bus.maddr    = maddr_q;
  assign bus.mdtw     = mdtw_q;
  assign bus.mrw      = mrw_q;
  assign bus.mreq     = mreq_q;
  assign bus.gnt      = gnt_q;
  assign bus.busy     = busy_q;
  assign dbg_state_o  = state_q;

endmodule
